// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues synchronous imem reads,
// buffers returned words in a 2-entry queue and hands them to decode.
// Redirects are tracked with an epoch bit. HLT is pre-decoded so that
// fetching stops cleanly once the HLT word has been handed off.
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_rdata,
  output logic [15:0]     inst,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus1,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            halted
);

  // HLT encoding: opcode class 2'b11 with sub-op 4'b1111
  function automatic logic is_hlt(input logic [15:0] word);
    return (word[15:14] == 2'b11) && (word[7:4] == 4'b1111);
  endfunction

  logic [PC_W-1:0] fetch_pc_r;
  logic [15:0]     fifo_inst_r [2];
  logic [PC_W-1:0] fifo_pc_r   [2];
  logic            rd_ptr_r;
  logic            wr_ptr_r;
  logic [1:0]      count_r;
  logic            inflight_r;
  logic            inflight_epoch_r;
  logic [PC_W-1:0] inflight_pc_r;
  logic            epoch_r;
  logic            halt_seen_r;
  logic            halted_r;

  logic            valid_s;
  logic            hs_s;
  logic            redir_s;
  logic            push_s;
  logic            issue_s;
  logic [2:0]      load_s;

  assign valid_s = (count_r != 2'd0) && !halted_r;
  assign hs_s    = valid_s && inst_ready;
  // Once halted the stage is frozen; redirects are ignored until reset
  assign redir_s = redirect && !halted_r;
  // Queue entries plus the word that returns this cycle
  assign load_s  = {1'b0, count_r} + {2'b00, inflight_r};
  // A returning word is kept only if it belongs to the current path,
  // no HLT has been queued ahead of it and no redirect flushes it now
  assign push_s  = inflight_r && (inflight_epoch_r == epoch_r) && !halt_seen_r && !redir_s;

  // Issue decision: never let queue + in-flight exceed two entries
  always_comb begin
    issue_s = 1'b0;
    if (rst || halt_seen_r || halted_r) begin
      issue_s = 1'b0;
    end else if (load_s <= 3'd1) begin
      issue_s = 1'b1;
    end else if ((load_s == 3'd2) && hs_s) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  assign imem_en    = issue_s;
  assign imem_addr  = fetch_pc_r;
  assign inst       = fifo_inst_r[rd_ptr_r];
  assign pc_out     = fifo_pc_r[rd_ptr_r];
  assign pc_plus1   = fifo_pc_r[rd_ptr_r] + {{(PC_W-1){1'b0}}, 1'b1};
  assign inst_valid = valid_s;
  assign halted     = halted_r;

  // PC, in-flight tracking, epoch and halt state
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r       <= RESET_PC;
      inflight_r       <= 1'b0;
      inflight_epoch_r <= 1'b0;
      inflight_pc_r    <= {PC_W{1'b0}};
      epoch_r          <= 1'b0;
      halt_seen_r      <= 1'b0;
      halted_r         <= 1'b0;
    end else begin
      inflight_r       <= issue_s;
      inflight_epoch_r <= epoch_r;
      inflight_pc_r    <= fetch_pc_r;
      if (redir_s) begin
        fetch_pc_r <= redirect_pc;
      end else if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + {{(PC_W-1){1'b0}}, 1'b1};
      end
      if (redir_s) begin
        epoch_r <= ~epoch_r;
      end
      if (redir_s) begin
        halt_seen_r <= 1'b0;
      end else if (push_s && is_hlt(imem_rdata)) begin
        halt_seen_r <= 1'b1;
      end
      if (hs_s && is_hlt(fifo_inst_r[rd_ptr_r])) begin
        halted_r <= 1'b1;
      end
    end
  end

  // Two-entry instruction queue; a redirect empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r       <= 1'b0;
      wr_ptr_r       <= 1'b0;
      count_r        <= 2'd0;
      fifo_inst_r[0] <= 16'h0000;
      fifo_inst_r[1] <= 16'h0000;
      fifo_pc_r[0]   <= {PC_W{1'b0}};
      fifo_pc_r[1]   <= {PC_W{1'b0}};
    end else if (redir_s) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_inst_r[wr_ptr_r] <= imem_rdata;
        fifo_pc_r[wr_ptr_r]   <= inflight_pc_r;
        wr_ptr_r              <= ~wr_ptr_r;
      end
      if (hs_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push_s, hs_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  fetch_stage_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .count (count_r)
  );

endmodule

// Checker: a returning word must never be written into a full queue
module fetch_stage_chk (
  input logic       clk,
  input logic       rst,
  input logic       push,
  input logic [1:0] count
);
  push_not_full_a: assert property (@(posedge clk) disable iff (rst) !(push && (count == 2'd2)));
endmodule
